// File: rtl/lfsr_prbs.sv
// PRBS generator and self-synchronising checker sharing one step function.
// Generator streams DATA_W bits per beat over valid/ready; checker counts word errors.
module lfsr_prbs #(
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = LFSR_W'(16'hB400),
  parameter int                DATA_W       = 8,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = LFSR_W'(1),
  parameter int                LOCK_CNT     = 4,
  parameter int                UNLOCK_CNT   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              LOAD,
  input  logic [LFSR_W-1:0] SEED,
  input  logic              EN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  input  logic [DATA_W-1:0] CHK_DIN,
  input  logic              CHK_VALID,
  input  logic              CLR_ERR,
  output logic              CHK_LOCKED,
  output logic [15:0]       ERR_CNT
);

  localparam int K  = (LFSR_W + DATA_W - 1) / DATA_W;
  localparam int CW = 8;

  localparam logic [CW-1:0] HUNT_LAST = CW'(K - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] DROP_LAST = CW'(UNLOCK_CNT - 1);
  localparam logic          K_ONE     = (K == 1);

  typedef struct packed {
    logic [LFSR_W-1:0] s;
    logic [DATA_W-1:0] w;
  } beat_t;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } chk_st_t;

  // First generated bit lands in the word MSB.
  function automatic beat_t step_beat(
    input logic [LFSR_W-1:0] s_in
  );
    beat_t b;
    logic  fb;
    b.s = s_in;
    b.w = '0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb     = ^(b.s & TAPS);
      b.s    = {b.s[LFSR_W-2:0], fb};
      b.w[i] = fb;
    end
    return b;
  endfunction

  logic [LFSR_W-1:0] gen_s;
  logic [LFSR_W-1:0] gen_cur;
  beat_t             gen_b;
  logic              advance;

  assign gen_cur = (gen_s == '0) ? DEFAULT_SEED : gen_s;
  assign gen_b   = step_beat(gen_cur);
  assign advance = EN && (!DOUT_VALID || DOUT_READY);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      gen_s      <= DEFAULT_SEED;
      DOUT       <= '0;
      DOUT_VALID <= 1'b0;
    end else if (LOAD) begin
      gen_s      <= (SEED == '0) ? DEFAULT_SEED : SEED;
      DOUT_VALID <= 1'b0;
    end else if (advance) begin
      gen_s      <= gen_b.s;
      DOUT       <= gen_b.w;
      DOUT_VALID <= 1'b1;
    end else begin
      gen_s <= gen_cur;
      if (DOUT_VALID && DOUT_READY) begin
        DOUT_VALID <= 1'b0;
      end
    end
  end

  chk_st_t           st_q, st_n;
  logic [LFSR_W-1:0] chk_s, chk_s_n;
  logic [LFSR_W-1:0] chk_shift;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [15:0]       err_q, err_n;
  beat_t             pred;
  logic              match;
  logic              locked_q;

  assign pred      = step_beat(chk_s);
  assign match     = (pred.w == CHK_DIN);
  assign chk_shift = LFSR_W'({chk_s, CHK_DIN});

  // cnt_q is the word count in HUNT, good count in SYNC, bad run in LOCKED.
  always_comb begin
    st_n    = st_q;
    chk_s_n = chk_s;
    cnt_n   = cnt_q;
    err_n   = err_q;
    if (CHK_VALID) begin
      unique case (st_q)
        HUNT: begin
          chk_s_n = chk_shift;
          cnt_n   = cnt_q + CW'(1);
          if (cnt_q == HUNT_LAST) begin
            st_n  = SYNC;
            cnt_n = '0;
          end
        end
        SYNC: begin
          if (match) begin
            chk_s_n = pred.s;
            cnt_n   = cnt_q + CW'(1);
            if (cnt_q == LOCK_LAST) begin
              st_n  = LOCKED;
              cnt_n = '0;
            end
          end else begin
            chk_s_n = chk_shift;
            st_n    = K_ONE ? SYNC : HUNT;
            cnt_n   = K_ONE ? '0 : CW'(1);
          end
        end
        LOCKED: begin
          chk_s_n = pred.s;
          if (match) begin
            cnt_n = '0;
          end else begin
            cnt_n = cnt_q + CW'(1);
            if (err_q != '1) begin
              err_n = err_q + 16'd1;
            end
            if (cnt_q == DROP_LAST) begin
              st_n  = HUNT;
              cnt_n = '0;
            end
          end
        end
        default: begin
          st_n  = HUNT;
          cnt_n = '0;
        end
      endcase
    end
    if (CLR_ERR) begin
      err_n = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q     <= HUNT;
      chk_s    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      st_q     <= st_n;
      chk_s    <= chk_s_n;
      cnt_q    <= cnt_n;
      err_q    <= err_n;
      locked_q <= (st_n == LOCKED);
    end
  end

  assign CHK_LOCKED = locked_q;
  assign ERR_CNT    = err_q;

endmodule

// File: tb/tb_lfsr_prbs.sv
// Scoreboard bench for lfsr_prbs in the 4-bit x^4+x^3+1 configuration.
// Generator output is looped into the checker; words are checked by a monitor.
module tb_lfsr_prbs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [3:0]  seed;
  logic        en;
  logic [3:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [3:0]  chk_din;
  logic        chk_valid;
  logic        clr_err;
  logic        chk_locked;
  logic [15:0] err_cnt;
  logic [3:0]  corrupt;
  logic        mon_en;

  int n_vec = 0;
  int n_bad = 0;
  int gi    = 0;

  logic [3:0] exp_q[$];
  logic [3:0] tbl[15];

  always #5 clk = ~clk;

  assign chk_din   = dout ^ corrupt;
  assign chk_valid = dout_valid & dout_ready;

  lfsr_prbs #(
    .LFSR_W      (4),
    .TAPS        (4'b1100),
    .DATA_W      (4),
    .DEFAULT_SEED(4'b0001),
    .LOCK_CNT    (4),
    .UNLOCK_CNT  (4)
  ) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .LOAD      (load),
    .SEED      (seed),
    .EN        (en),
    .DOUT      (dout),
    .DOUT_VALID(dout_valid),
    .DOUT_READY(dout_ready),
    .CHK_DIN   (chk_din),
    .CHK_VALID (chk_valid),
    .CLR_ERR   (clr_err),
    .CHK_LOCKED(chk_locked),
    .ERR_CNT   (err_cnt)
  );

  always @(negedge clk) begin
    if (rst_n && mon_en && dout_valid && dout_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL dout_extra: got %h want none", dout);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (dout !== e) begin
          n_bad++;
          $display("FAIL dout: got %h want %h", dout, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic word(input logic [3:0] mask, input logic clr);
    exp_q.push_back(tbl[gi % 15]);
    gi++;
    en = 1'b1;
    tick();
    en      = 1'b0;
    corrupt = mask;
    clr_err = clr;
    tick();
    corrupt = '0;
    clr_err = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) word(4'h0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    exp_q.delete();
    gi    = 0;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl = '{4'h3, 4'h5, 4'hE, 4'h2, 4'h6, 4'hB, 4'hC, 4'h4,
            4'hD, 4'h7, 4'h8, 4'h9, 4'hA, 4'hF, 4'h1};
    rst_n = 1'b0; load = 1'b0; seed = '0; en = 1'b0;
    dout_ready = 1'b1; clr_err = 1'b0; corrupt = '0;
    mon_en = 1'b1;
    tick();
    tick();
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_locked", 32'(chk_locked), 32'h0);
    chk("rst_err", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    stream(16);
    chk("seq_drain", 32'(exp_q.size()), 32'h0);

    do_reset();
    dout_ready = 1'b0;
    en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_dout", 32'(dout), 32'h3);
      chk("bp_valid", 32'(dout_valid), 32'h1);
      tick();
    end
    exp_q.push_back(tbl[0]);
    exp_q.push_back(tbl[1]);
    gi = 2;
    dout_ready = 1'b1;
    tick();
    en = 1'b0;
    tick();
    tick();
    chk("bp_drain", 32'(exp_q.size()), 32'h0);

    do_reset();
    dout_ready = 1'b0;
    en = 1'b1;
    tick();
    chk("ld_pend", 32'(dout_valid), 32'h1);
    en = 1'b0; load = 1'b1; seed = 4'b0011;
    tick();
    load = 1'b0;
    chk("ld_valid", 32'(dout_valid), 32'h0);
    chk("ld_dout", 32'(dout), 32'h3);
    dout_ready = 1'b1;
    gi = 1;
    word(4'h0, 1'b0);
    load = 1'b1; seed = 4'b0000;
    tick();
    load = 1'b0;
    gi = 0;
    stream(2);
    chk("ld_drain", 32'(exp_q.size()), 32'h0);

    do_reset();
    stream(4);
    chk("lock_early", 32'(chk_locked), 32'h0);
    stream(1);
    chk("lock_on", 32'(chk_locked), 32'h1);
    stream(1000);
    chk("lock_err", 32'(err_cnt), 32'h0);
    chk("lock_hold", 32'(chk_locked), 32'h1);

    word(4'b0100, 1'b0);
    chk("flip_err", 32'(err_cnt), 32'h1);
    chk("flip_lock", 32'(chk_locked), 32'h1);
    word(4'h0, 1'b0);
    for (int i = 0; i < 3; i++) word(4'hF, 1'b0);
    chk("bad3_lock", 32'(chk_locked), 32'h1);
    chk("bad3_err", 32'(err_cnt), 32'h4);
    word(4'hF, 1'b0);
    chk("bad4_lock", 32'(chk_locked), 32'h0);
    chk("bad4_err", 32'(err_cnt), 32'h5);
    stream(4);
    chk("relock_early", 32'(chk_locked), 32'h0);
    stream(1);
    chk("relock", 32'(chk_locked), 32'h1);
    chk("relock_err", 32'(err_cnt), 32'h5);
    word(4'b1000, 1'b1);
    chk("clr_err", 32'(err_cnt), 32'h0);
    chk("clr_lock", 32'(chk_locked), 32'h1);
    word(4'h0, 1'b0);

    force dut.err_q = 16'hFFFD;
    #1;
    release dut.err_q;
    word(4'h1, 1'b0);
    chk("sat_fffe", 32'(err_cnt), 32'hFFFE);
    word(4'h1, 1'b0);
    chk("sat_ffff", 32'(err_cnt), 32'hFFFF);
    word(4'h0, 1'b0);
    word(4'h1, 1'b0);
    chk("sat_hold", 32'(err_cnt), 32'hFFFF);
    chk("sat_lock", 32'(chk_locked), 32'h1);
    chk("sat_drain", 32'(exp_q.size()), 32'h0);

    mon_en = 1'b0;
    en = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_valid", 32'(dout_valid), 32'h0);
    chk("arst_locked", 32'(chk_locked), 32'h0);
    chk("arst_err", 32'(err_cnt), 32'h0);
    en = 1'b0;
    #10;
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    gi = 0;
    mon_en = 1'b1;
    word(4'h0, 1'b0);
    chk("arst_drain", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
